// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher: byte-serial key+ciphertext in, byte-serial plaintext out.
// Latency: 21 cycles from the edge accepting the 16th input beat to out_valid.
// Backpressure: in_ready low while a block is in flight; output holds stable while out_ready is low.

module aes_sbox #(
    parameter bit INV = 1'b0
) (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    generate
        if (INV) begin : g_inv
            assign y = ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
        end else begin : g_fwd
            logic [7:0] v;
            assign v = ginv(a);
            assign y = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                         ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
    endgenerate
endmodule

module aes_decryption #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] key_byte,
    input  logic [7:0] ct_byte,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pt_byte,
    output logic       out_last
);
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {IDLE, LOAD, KEXP, INIT, RND, FINAL, OUT} fsm_t;

    fsm_t         fsm;
    logic [127:0] rkey;
    logic [127:0] state;
    logic [3:0]   cnt;
    logic [3:0]   rnd;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte k (0 = MSB) sits at bits [127-8k -: 8]; row r of column c is byte 4c+r
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            logic [7:0] x2, x4, x8;
            a[i]  = col[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [7:0] byte_at(input logic [127:0] s, input logic [3:0] i);
        logic [127:0] t;
        t = s << {i, 3'b000};
        return t[127:120];
    endfunction

    // Key schedule: one shared SubWord serves forward and inverse steps
    logic [31:0] w0, w1, w2, w3, pw3, sub_in, sub_out, tw;
    logic [127:0] kexp_next, kinv_next;

    assign {w0, w1, w2, w3} = rkey;
    assign pw3    = w3 ^ w2;
    assign sub_in = (fsm == KEXP) ? {w3[23:0], w3[31:24]} : {pw3[23:0], pw3[31:24]};
    assign tw     = sub_out ^ {rcon(rnd), 24'h000000};

    always_comb begin
        logic [31:0] n0, n1, n2;
        n0        = w0 ^ tw;
        n1        = w1 ^ n0;
        n2        = w2 ^ n1;
        kexp_next = {n0, n1, n2, w3 ^ n2};
    end

    assign kinv_next = {w0 ^ tw, w1 ^ w0, w2 ^ w1, pw3};

    logic [127:0] isb_in, isb_out, after_ark, mixed;
    assign isb_in = inv_shift_rows(state);

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_ksub
            aes_sbox #(.INV(1'b0)) u_sbox (.a(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
        end
        for (g = 0; g < 16; g++) begin : g_isub
            aes_sbox #(.INV(1'b1)) u_isbox (.a(isb_in[8*g +: 8]), .y(isb_out[8*g +: 8]));
        end
    endgenerate

    assign after_ark = isb_out ^ rkey;
    assign mixed     = inv_mix_columns(after_ark);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            rkey      <= '0;
            state     <= '0;
            cnt       <= '0;
            rnd       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            pt_byte   <= 8'h00;
            out_last  <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        rkey  <= {rkey[119:0], key_byte};
                        state <= {state[119:0], ct_byte};
                        cnt   <= 4'd1;
                        busy  <= 1'b1;
                        fsm   <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        rkey  <= {rkey[119:0], key_byte};
                        state <= {state[119:0], ct_byte};
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            in_ready <= 1'b0;
                            rnd      <= 4'd1;
                            fsm      <= KEXP;
                        end
                    end
                end
                KEXP: begin
                    rkey <= kexp_next;
                    if (rnd == LAST_RND) fsm <= INIT;
                    else                 rnd <= rnd + 4'd1;
                end
                INIT: begin
                    state <= state ^ rkey;
                    rkey  <= kinv_next;
                    rnd   <= rnd - 4'd1;
                    fsm   <= RND;
                end
                RND: begin
                    state <= mixed;
                    rkey  <= kinv_next;
                    rnd   <= rnd - 4'd1;
                    if (rnd == 4'd1) fsm <= FINAL;
                end
                FINAL: begin
                    state     <= after_ark;
                    pt_byte   <= after_ark[127:120];
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    cnt       <= 4'd0;
                    fsm       <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        if (cnt == 4'd15) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            cnt       <= 4'd0;
                            fsm       <= IDLE;
                        end else begin
                            cnt      <= cnt + 4'd1;
                            pt_byte  <= byte_at(state, cnt + 4'd1);
                            out_last <= (cnt == 4'd14);
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decryption.sv
// Directed-vector bench for aes_decryption using FIPS-197 known-answer blocks.
module tb_aes_decryption;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] key_byte = 8'h00;
    logic [7:0] ct_byte = 8'h00;
    logic       busy;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] pt_byte;
    logic       out_last;

    int total = 0;
    int bad = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_decryption #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .key_byte(key_byte), .ct_byte(ct_byte), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .pt_byte(pt_byte), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns just after the edge that accepts the 16th beat
    task automatic send_block(input logic [127:0] k, input logic [127:0] ct,
                              input bit gaps, input bit hold);
        int i = 0;
        int guard = 0;
        int rdy_bad = 0;
        while (i < 16 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (i > 0 && in_ready !== 1'b1) rdy_bad++;
            if (gaps && (guard % 2 == 0)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                key_byte = k[127-8*i -: 8];
                ct_byte  = ct[127-8*i -: 8];
                if (in_ready === 1'b1) i++;
            end
        end
        total++;
        if (i < 16) begin
            bad++;
            $display("FAIL send_timeout: beats accepted=%0d required=16", i);
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        if (gaps) begin
            total++;
            if (rdy_bad != 0) begin
                bad++;
                $display("FAIL load_in_ready: cycles with in_ready low during LOAD=%0d required=0", rdy_bad);
            end
        end
    endtask

    task automatic recv_block(input logic [127:0] exp, input int stall_at, input bit chk_rdy);
        int j = 0;
        int guard = 0;
        int stall = 0;
        int rdy_bad = 0;
        logic [127:0] got = '0;
        while (j < 16 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (chk_rdy && in_ready !== 1'b0) rdy_bad++;
            if (j == stall_at && stall < 5 && (stall > 0 || out_valid === 1'b1)) begin
                out_ready = 1'b0;
                stall++;
                total++;
                if (out_valid !== 1'b1 || pt_byte !== exp[127-8*j -: 8]) begin
                    bad++;
                    $display("FAIL stall_hold: out_valid=%b pt_byte=%h required out_valid=1 pt_byte=%h",
                             out_valid, pt_byte, exp[127-8*j -: 8]);
                end
            end else begin
                out_ready = 1'b1;
                if (out_valid === 1'b1) begin
                    total++;
                    if (pt_byte !== exp[127-8*j -: 8] || out_last !== (j == 15)) begin
                        bad++;
                        $display("FAIL out_beat%0d: pt_byte=%h out_last=%b required pt_byte=%h out_last=%b",
                                 j, pt_byte, out_last, exp[127-8*j -: 8], (j == 15));
                    end
                    got[127-8*j -: 8] = pt_byte;
                    j++;
                end
            end
        end
        total++;
        if (j < 16) begin
            bad++;
            $display("FAIL recv_timeout: beats received=%0d required=16", j);
        end
        @(posedge clk);
        #1;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL plaintext: got=%h required=%h", got, exp);
        end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL end_of_block: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        if (chk_rdy) begin
            total++;
            if (rdy_bad != 0) begin
                bad++;
                $display("FAIL busy_in_ready: cycles with in_ready high while busy=%0d required=0", rdy_bad);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 ||
            pt_byte !== 8'h00 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL %s: in_ready=%b busy=%b out_valid=%b pt_byte=%h out_last=%b required 0 0 0 00 0",
                     tag, in_ready, busy, out_valid, pt_byte, out_last);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset: in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic test_fips_c1();
        int n = 0;
        send_block(C1_KEY, C1_CT, 1'b0, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_set: busy=%b required=1", busy);
        end
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid === 1'b1) break;
        end
        total++;
        if (n != 21) begin
            bad++;
            $display("FAIL latency: cycles=%0d required=21", n);
        end
        recv_block(C1_PT, -1, 1'b0);
    endtask

    task automatic test_fips_b();
        send_block(B_KEY, B_CT, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (dut.rkey !== B_K10) begin
            bad++;
            $display("FAIL round10_key: key=%h required=%h", dut.rkey, B_K10);
        end
        recv_block(B_PT, -1, 1'b0);
    endtask

    task automatic test_valid_gaps();
        send_block(C1_KEY, C1_CT, 1'b1, 1'b0);
        recv_block(C1_PT, -1, 1'b0);
    endtask

    task automatic test_out_stall();
        send_block(C1_KEY, C1_CT, 1'b0, 1'b0);
        recv_block(C1_PT, 7, 1'b0);
    endtask

    task automatic test_reset_mid_round();
        send_block(C1_KEY, C1_CT, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        total++;
        if (dut.rnd !== 4'd5) begin
            bad++;
            $display("FAIL round_index: rnd=%0d required=5", dut.rnd);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_round");
        @(negedge clk);
        rst = 1'b0;
        send_block(C1_KEY, C1_CT, 1'b0, 1'b0);
        recv_block(C1_PT, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_block(C1_KEY, C1_CT, 1'b0, 1'b1);
        key_byte = B_KEY[127:120];
        ct_byte  = B_CT[127:120];
        recv_block(C1_PT, -1, 1'b1);
        send_block(B_KEY, B_CT, 1'b0, 1'b0);
        recv_block(B_PT, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_valid_gaps();
        test_out_stall();
        test_reset_mid_round();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
